// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI-Lite 2:1 arbiter.
package axil_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR_ACCEPT,
    WR_ISSUE,
    WR_RESP,
    WR_RET,
    RD_ACCEPT,
    RD_ISSUE,
    RD_RESP,
    RD_RET
  } arb_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-request pick with round-robin pointer.
// AXIL_ARB_FIXED_PRIO_EN: port 0 wins contested picks and the pointer is frozen.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       served,
  output logic       grant_c,
  output logic       valid_c,
  output logic       ptr_next_c
);

  always_comb begin
    valid_c    = |req;
    grant_c    = 1'b0;
    ptr_next_c = ptr;
`ifdef AXIL_ARB_FIXED_PRIO_EN
    grant_c    = ~req[0] & req[1];
`else
    // Contested pick follows the pointer; a lone request always wins.
    grant_c    = (req == 2'b11) ? ptr : req[1];
    ptr_next_c = ~served;
`endif
  end

`ifdef AXIL_ARB_FIXED_PRIO_EN
  logic unused_served;
  assign unused_served = served;
`endif

endmodule

// File: rtl/axil_arbiter_2to1.sv
// Two-to-one AXI-Lite arbiter; one downstream transaction at a time, fully registered outputs.
// Build option AXIL_ARB_FIXED_PRIO_EN (inside rr_arbiter2) selects fixed priority.
module axil_arbiter_2to1
  import axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                           axi_aclk,
  input  logic                           axi_aresetn,
  input  logic [2*ADDR_WIDTH-1:0]        s_axi_awaddr,
  input  logic [1:0]                     s_axi_awvalid,
  output logic [1:0]                     s_axi_awready,
  input  logic [2*DATA_WIDTH-1:0]        s_axi_wdata,
  input  logic [2*(DATA_WIDTH/8)-1:0]    s_axi_wstrb,
  input  logic [1:0]                     s_axi_wvalid,
  output logic [1:0]                     s_axi_wready,
  output logic [3:0]                     s_axi_bresp,
  output logic [1:0]                     s_axi_bvalid,
  input  logic [1:0]                     s_axi_bready,
  input  logic [2*ADDR_WIDTH-1:0]        s_axi_araddr,
  input  logic [1:0]                     s_axi_arvalid,
  output logic [1:0]                     s_axi_arready,
  output logic [2*DATA_WIDTH-1:0]        s_axi_rdata,
  output logic [3:0]                     s_axi_rresp,
  output logic [1:0]                     s_axi_rvalid,
  input  logic [1:0]                     s_axi_rready,
  output logic [ADDR_WIDTH-1:0]          m_axi_awaddr,
  output logic                           m_axi_awvalid,
  input  logic                           m_axi_awready,
  output logic [DATA_WIDTH-1:0]          m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]        m_axi_wstrb,
  output logic                           m_axi_wvalid,
  input  logic                           m_axi_wready,
  input  logic [1:0]                     m_axi_bresp,
  input  logic                           m_axi_bvalid,
  output logic                           m_axi_bready,
  output logic [ADDR_WIDTH-1:0]          m_axi_araddr,
  output logic                           m_axi_arvalid,
  input  logic                           m_axi_arready,
  input  logic [DATA_WIDTH-1:0]          m_axi_rdata,
  input  logic [1:0]                     m_axi_rresp,
  input  logic                           m_axi_rvalid,
  output logic                           m_axi_rready,
  output logic                           arb_busy,
  output logic                           arb_grant
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  arb_state_e state, state_n;
  logic ptr, ptr_n, grant_n, busy_n;

  logic [1:0]              s_awready_n, s_wready_n, s_bvalid_n, s_arready_n, s_rvalid_n;
  logic [3:0]              s_bresp_n, s_rresp_n;
  logic [2*DATA_WIDTH-1:0] s_rdata_n;
  logic [ADDR_WIDTH-1:0]   m_awaddr_n, m_araddr_n;
  logic [DATA_WIDTH-1:0]   m_wdata_n;
  logic [STRB_WIDTH-1:0]   m_wstrb_n;
  logic                    m_awvalid_n, m_wvalid_n, m_bready_n, m_arvalid_n, m_rready_n;

  logic [1:0]  wr_req_c, req_c;
  logic        win_c, win_valid_c, ptr_next_c;
  int unsigned wi, gi;

  assign wr_req_c = s_axi_awvalid & s_axi_wvalid;
  assign req_c    = wr_req_c | s_axi_arvalid;
  assign wi       = 32'(win_c);
  assign gi       = 32'(arb_grant);

  rr_arbiter2 u_pick (
    .req        (req_c),
    .ptr        (ptr),
    .served     (arb_grant),
    .grant_c    (win_c),
    .valid_c    (win_valid_c),
    .ptr_next_c (ptr_next_c)
  );

  // Next state and next register values; everything holds unless a transition changes it.
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    grant_n     = arb_grant;
    s_awready_n = s_axi_awready;
    s_wready_n  = s_axi_wready;
    s_bvalid_n  = s_axi_bvalid;
    s_bresp_n   = s_axi_bresp;
    s_arready_n = s_axi_arready;
    s_rvalid_n  = s_axi_rvalid;
    s_rresp_n   = s_axi_rresp;
    s_rdata_n   = s_axi_rdata;
    m_awaddr_n  = m_axi_awaddr;
    m_awvalid_n = m_axi_awvalid;
    m_wdata_n   = m_axi_wdata;
    m_wstrb_n   = m_axi_wstrb;
    m_wvalid_n  = m_axi_wvalid;
    m_bready_n  = m_axi_bready;
    m_araddr_n  = m_axi_araddr;
    m_arvalid_n = m_axi_arvalid;
    m_rready_n  = m_axi_rready;

    case (state)
      IDLE: begin
        if (win_valid_c) begin
          grant_n = win_c;
          // A write beats a read from the same port.
          if (wr_req_c[win_c]) begin
            state_n            = WR_ACCEPT;
            m_awaddr_n         = s_axi_awaddr[wi*ADDR_WIDTH +: ADDR_WIDTH];
            m_wdata_n          = s_axi_wdata[wi*DATA_WIDTH +: DATA_WIDTH];
            m_wstrb_n          = s_axi_wstrb[wi*STRB_WIDTH +: STRB_WIDTH];
            s_awready_n[win_c] = 1'b1;
            s_wready_n[win_c]  = 1'b1;
          end else begin
            state_n            = RD_ACCEPT;
            m_araddr_n         = s_axi_araddr[wi*ADDR_WIDTH +: ADDR_WIDTH];
            s_arready_n[win_c] = 1'b1;
          end
        end
      end
      WR_ACCEPT: begin
        s_awready_n = '0;
        s_wready_n  = '0;
        m_awvalid_n = 1'b1;
        m_wvalid_n  = 1'b1;
        state_n     = WR_ISSUE;
      end
      WR_ISSUE: begin
        if (m_axi_awvalid && m_axi_awready) m_awvalid_n = 1'b0;
        if (m_axi_wvalid && m_axi_wready)   m_wvalid_n  = 1'b0;
        if (!m_awvalid_n && !m_wvalid_n) begin
          m_bready_n = 1'b1;
          state_n    = WR_RESP;
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid && m_axi_bready) begin
          m_bready_n              = 1'b0;
          s_bresp_n[gi*2 +: 2]    = m_axi_bresp;
          s_bvalid_n[arb_grant]   = 1'b1;
          state_n                 = WR_RET;
        end
      end
      WR_RET: begin
        if (s_axi_bvalid[arb_grant] && s_axi_bready[arb_grant]) begin
          s_bvalid_n[arb_grant] = 1'b0;
          ptr_n                 = ptr_next_c;
          state_n               = IDLE;
        end
      end
      RD_ACCEPT: begin
        s_arready_n = '0;
        m_arvalid_n = 1'b1;
        state_n     = RD_ISSUE;
      end
      RD_ISSUE: begin
        if (m_axi_arvalid && m_axi_arready) begin
          m_arvalid_n = 1'b0;
          m_rready_n  = 1'b1;
          state_n     = RD_RESP;
        end
      end
      RD_RESP: begin
        if (m_axi_rvalid && m_axi_rready) begin
          m_rready_n                          = 1'b0;
          s_rdata_n[gi*DATA_WIDTH +: DATA_WIDTH] = m_axi_rdata;
          s_rresp_n[gi*2 +: 2]                = m_axi_rresp;
          s_rvalid_n[arb_grant]               = 1'b1;
          state_n                             = RD_RET;
        end
      end
      RD_RET: begin
        if (s_axi_rvalid[arb_grant] && s_axi_rready[arb_grant]) begin
          s_rvalid_n[arb_grant] = 1'b0;
          ptr_n                 = ptr_next_c;
          state_n               = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  // State, pointer and every output register.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state         <= IDLE;
      ptr           <= 1'b0;
      arb_grant     <= 1'b0;
      arb_busy      <= 1'b0;
      s_axi_awready <= '0;
      s_axi_wready  <= '0;
      s_axi_bvalid  <= '0;
      s_axi_bresp   <= '0;
      s_axi_arready <= '0;
      s_axi_rvalid  <= '0;
      s_axi_rresp   <= '0;
      s_axi_rdata   <= '0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      state         <= state_n;
      ptr           <= ptr_n;
      arb_grant     <= grant_n;
      arb_busy      <= busy_n;
      s_axi_awready <= s_awready_n;
      s_axi_wready  <= s_wready_n;
      s_axi_bvalid  <= s_bvalid_n;
      s_axi_bresp   <= s_bresp_n;
      s_axi_arready <= s_arready_n;
      s_axi_rvalid  <= s_rvalid_n;
      s_axi_rresp   <= s_rresp_n;
      s_axi_rdata   <= s_rdata_n;
      m_axi_awaddr  <= m_awaddr_n;
      m_axi_awvalid <= m_awvalid_n;
      m_axi_wdata   <= m_wdata_n;
      m_axi_wstrb   <= m_wstrb_n;
      m_axi_wvalid  <= m_wvalid_n;
      m_axi_bready  <= m_bready_n;
      m_axi_araddr  <= m_araddr_n;
      m_axi_arvalid <= m_arvalid_n;
      m_axi_rready  <= m_rready_n;
    end
  end

endmodule

// File: tb/tb_axil_arbiter_2to1.sv
// Self-checking bench for axil_arbiter_2to1: vector table plus arbitration/reset sequences.
module tb_axil_arbiter_2to1;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned SW = DW / 8;

  logic            axi_aclk, axi_aresetn;
  logic [2*AW-1:0] s_axi_awaddr, s_axi_araddr;
  logic [1:0]      s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [2*DW-1:0] s_axi_wdata, s_axi_rdata;
  logic [2*SW-1:0] s_axi_wstrb;
  logic [3:0]      s_axi_bresp, s_axi_rresp;
  logic [1:0]      s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic [1:0]      s_axi_rvalid, s_axi_rready;
  logic [AW-1:0]   m_axi_awaddr, m_axi_araddr;
  logic            m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [DW-1:0]   m_axi_wdata, m_axi_rdata;
  logic [SW-1:0]   m_axi_wstrb;
  logic [1:0]      m_axi_bresp, m_axi_rresp;
  logic            m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic            m_axi_rvalid, m_axi_rready;
  logic            arb_busy, arb_grant;

  int n_tests = 0;
  int n_fail  = 0;

  logic          slv_en;
  logic [1:0]    slv_resp;
  logic [DW-1:0] slv_rdata;

  axil_arbiter_2to1 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .arb_busy(arb_busy), .arb_grant(arb_grant)
  );

  initial begin
    axi_aclk = 1'b0;
    forever #5 axi_aclk = ~axi_aclk;
  end

  // Downstream slave: answers one cycle after it sees bready/rready.
  initial begin
    forever begin
      @(negedge axi_aclk);
      if (slv_en) begin
        m_axi_bvalid = m_axi_bready;
        m_axi_bresp  = slv_resp;
        m_axi_rvalid = m_axi_rready;
        m_axi_rresp  = slv_resp;
        m_axi_rdata  = slv_rdata;
      end
    end
  end

  typedef struct {
    int            port;
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [1:0]    resp;
    logic [1:0]    exp_resp;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    s_axi_awaddr = '0; s_axi_awvalid = '0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = '0; s_axi_araddr = '0; s_axi_arvalid = '0;
    s_axi_bready = 2'b11; s_axi_rready = 2'b11;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
    m_axi_bvalid = 1'b0; m_axi_bresp = '0; m_axi_rvalid = 1'b0; m_axi_rresp = '0;
    m_axi_rdata = '0;
  endtask

  task automatic drain();
    int cyc = 0;
    while (arb_busy && cyc < 40) begin
      @(negedge axi_aclk);
      cyc++;
    end
    check("drain_idle", 64'(arb_busy), 64'd0);
  endtask

  // One single-port transaction with a zero-wait slave, latency checked per cycle.
  task automatic run_txn(input vec_t v);
    int  cyc;
    int  p;
    int  q;
    bit  done;
    p = v.port;
    q = 1 - p;
    @(negedge axi_aclk);
    slv_resp  = v.resp;
    slv_rdata = v.data;
    if (v.is_wr) begin
      s_axi_awaddr[p*AW +: AW] = v.addr;
      s_axi_wdata[p*DW +: DW]  = v.data;
      s_axi_wstrb[p*SW +: SW]  = v.strb;
      s_axi_awvalid[p] = 1'b1;
      s_axi_wvalid[p]  = 1'b1;
    end else begin
      s_axi_araddr[p*AW +: AW] = v.addr;
      s_axi_arvalid[p] = 1'b1;
    end
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 20) begin
      @(negedge axi_aclk);
      cyc++;
      done = v.is_wr ? s_axi_awready[p] : s_axi_arready[p];
    end
    check("s_ready_latency", 64'(cyc), 64'd1);
    @(negedge axi_aclk);
    cyc++;
    s_axi_awvalid[p] = 1'b0;
    s_axi_wvalid[p]  = 1'b0;
    s_axi_arvalid[p] = 1'b0;
    check("grant", 64'(arb_grant), 64'(p));
    if (v.is_wr) begin
      check("m_awvalid_cycle2", 64'(m_axi_awvalid), 64'd1);
      check("m_wvalid_cycle2", 64'(m_axi_wvalid), 64'd1);
      check("m_awaddr", 64'(m_axi_awaddr), 64'(v.addr));
      check("m_wdata", 64'(m_axi_wdata), 64'(v.data));
      check("m_wstrb", 64'(m_axi_wstrb), 64'(v.strb));
      check("other_port_awready", 64'(s_axi_awready[q]), 64'd0);
    end else begin
      check("m_arvalid_cycle2", 64'(m_axi_arvalid), 64'd1);
      check("m_araddr", 64'(m_axi_araddr), 64'(v.addr));
      check("other_port_arready", 64'(s_axi_arready[q]), 64'd0);
    end
    done = 1'b0;
    while (!done && cyc < 30) begin
      @(negedge axi_aclk);
      cyc++;
      done = v.is_wr ? s_axi_bvalid[p] : s_axi_rvalid[p];
    end
    check("s_resp_latency", 64'(cyc), 64'd4);
    if (v.is_wr) begin
      check("s_bresp", 64'(s_axi_bresp[p*2 +: 2]), 64'(v.exp_resp));
      check("other_port_bvalid", 64'(s_axi_bvalid[q]), 64'd0);
    end else begin
      check("s_rresp", 64'(s_axi_rresp[p*2 +: 2]), 64'(v.exp_resp));
      check("s_rdata", 64'(s_axi_rdata[p*DW +: DW]), 64'(v.exp_rdata));
      check("other_port_rvalid", 64'(s_axi_rvalid[q]), 64'd0);
    end
    @(negedge axi_aclk);
    check("idle_after_return", 64'(arb_busy), 64'd0);
  endtask

  initial begin
    int          n;
    int          order[4];
    int          when[4];
    int          ev[2];
    bit          pend_w, pend_r;
    logic [1:0]  rnd;
    int          exp_order[4];

    tbl[0] = '{0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 2'b00, 2'b00, 32'h0};
    tbl[1] = '{1, 1'b0, 8'h20, 32'h12345678, 4'h0, 2'b10, 2'b10, 32'h12345678};
    tbl[2] = '{1, 1'b1, 8'h44, 32'hA5A5A5A5, 4'h3, 2'b10, 2'b10, 32'h0};
    tbl[3] = '{0, 1'b0, 8'h80, 32'hCAFEF00D, 4'h0, 2'b00, 2'b00, 32'hCAFEF00D};
    tbl[4] = '{0, 1'b1, 8'hFF, 32'hFFFFFFFF, 4'h8, 2'b00, 2'b00, 32'h0};
    tbl[5] = '{1, 1'b0, 8'h00, 32'h00000000, 4'h0, 2'b00, 2'b00, 32'h0};

    // Reset with random inputs toggling.
    slv_en = 1'b0; slv_resp = '0; slv_rdata = '0;
    axi_aresetn = 1'b0;
    clear_inputs();
    for (int i = 0; i < 6; i++) begin
      @(negedge axi_aclk);
      s_axi_awaddr  = 16'($urandom); s_axi_araddr = 16'($urandom);
      s_axi_wdata   = {$urandom, $urandom}; s_axi_wstrb = 8'($urandom);
      rnd = 2'($urandom); s_axi_awvalid = rnd;
      rnd = 2'($urandom); s_axi_wvalid  = rnd;
      rnd = 2'($urandom); s_axi_arvalid = rnd;
      rnd = 2'($urandom); s_axi_bready  = rnd;
      rnd = 2'($urandom); m_axi_bvalid  = rnd[0]; m_axi_rvalid = rnd[1];
      m_axi_awready = 1'($urandom); m_axi_arready = 1'($urandom);
    end
    check("rst_s_awready", 64'(s_axi_awready), 64'd0);
    check("rst_s_wready", 64'(s_axi_wready), 64'd0);
    check("rst_s_bvalid", 64'(s_axi_bvalid), 64'd0);
    check("rst_s_arready", 64'(s_axi_arready), 64'd0);
    check("rst_s_rvalid", 64'(s_axi_rvalid), 64'd0);
    check("rst_m_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}), 64'd0);
    check("rst_m_readies", 64'({m_axi_bready, m_axi_rready}), 64'd0);
    check("rst_m_awaddr", 64'(m_axi_awaddr), 64'd0);
    check("rst_s_rdata", s_axi_rdata, 64'd0);
    check("rst_busy", 64'(arb_busy), 64'd0);
    check("rst_grant", 64'(arb_grant), 64'd0);
    clear_inputs();
    slv_en = 1'b1;
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;

    for (int i = 0; i < 6; i++) run_txn(tbl[i]);

    // Port 0 write and read together: write accepted first.
    @(negedge axi_aclk);
    s_axi_awaddr[7:0] = 8'h31; s_axi_wdata[31:0] = 32'h0BADF00D; s_axi_wstrb[3:0] = 4'hF;
    s_axi_araddr[7:0] = 8'h33;
    s_axi_awvalid[0] = 1'b1; s_axi_wvalid[0] = 1'b1; s_axi_arvalid[0] = 1'b1;
    n = 0; pend_w = 1'b0; pend_r = 1'b0;
    for (int c = 0; c < 60 && n < 2; c++) begin
      @(negedge axi_aclk);
      if (pend_w) begin s_axi_awvalid[0] = 1'b0; s_axi_wvalid[0] = 1'b0; pend_w = 1'b0; end
      if (pend_r) begin s_axi_arvalid[0] = 1'b0; pend_r = 1'b0; end
      if (s_axi_awready[0] && n < 2) begin ev[n] = 0; n++; pend_w = 1'b1; end
      if (s_axi_arready[0] && n < 2) begin ev[n] = 1; n++; pend_r = 1'b1; end
    end
    check("wr_rd_events", 64'(n), 64'd2);
    check("wr_first", 64'(ev[0]), 64'd0);
    check("rd_second", 64'(ev[1]), 64'd1);
    @(negedge axi_aclk);
    s_axi_arvalid[0] = 1'b0; s_axi_awvalid[0] = 1'b0; s_axi_wvalid[0] = 1'b0;
    check("wr_rd_araddr", 64'(m_axi_araddr), 64'h33);
    drain();

    // Both ports write continuously from reset.
    @(negedge axi_aclk);
    axi_aresetn = 1'b0;
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    s_axi_awaddr = 16'h5150; s_axi_wdata = {32'h11111111, 32'h00000000}; s_axi_wstrb = 8'hFF;
    s_axi_awvalid = 2'b11; s_axi_wvalid = 2'b11;
    n = 0;
    for (int c = 0; c < 100 && n < 4; c++) begin
      @(negedge axi_aclk);
      if (|s_axi_awready) begin order[n] = int'(s_axi_awready[1]); when[n] = c; n++; end
    end
`ifdef AXIL_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    check("rr_count", 64'(n), 64'd4);
    for (int i = 0; i < 4; i++) check($sformatf("rr_order[%0d]", i), 64'(order[i]), 64'(exp_order[i]));
    for (int i = 1; i < 4; i++) check($sformatf("rr_gap[%0d]", i), 64'(when[i] - when[i-1]), 64'd5);
    @(negedge axi_aclk);
    s_axi_awvalid = '0; s_axi_wvalid = '0;
    drain();

    // Reset while stuck in WR_ISSUE after port 0 was served last.
    run_txn(tbl[0]);
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    s_axi_awaddr[15:8] = 8'h77; s_axi_awvalid[1] = 1'b1; s_axi_wvalid[1] = 1'b1;
    n = 0;
    while (!m_axi_awvalid && n < 20) begin @(negedge axi_aclk); n++; end
    check("issue_awvalid", 64'(m_axi_awvalid), 64'd1);
    check("issue_grant", 64'(arb_grant), 64'd1);
    @(negedge axi_aclk);
    check("issue_hold", 64'({m_axi_awvalid, m_axi_wvalid}), 64'h3);
    #2 axi_aresetn = 1'b0;
    #1;
    check("async_rst_m_valids", 64'({m_axi_awvalid, m_axi_wvalid}), 64'd0);
    check("async_rst_busy", 64'(arb_busy), 64'd0);
    m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    s_axi_awvalid = 2'b11; s_axi_wvalid = 2'b11;
    n = 0;
    while (!(|s_axi_awready) && n < 20) begin @(negedge axi_aclk); n++; end
    check("post_rst_winner", 64'(s_axi_awready), 64'h1);
    @(negedge axi_aclk);
    s_axi_awvalid = '0; s_axi_wvalid = '0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
